// File: rtl/usr_pkg.sv
// usr_pkg: shared mode and state encodings for the universal shift register
package usr_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  localparam logic [2:0] MODE_SHL = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_ROL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;
  function automatic logic mode_valid(input logic [2:0] m);
    return m <= MODE_ASR;
  endfunction
endpackage

// File: rtl/usr_step.sv
// usr_step: one combinational shift/rotate step selected by mode
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             SI_L,
  input  logic             SI_R,
  output logic [WIDTH-1:0] q_next
);
  always_comb
    q_next = mode == MODE_SHL ? {q[WIDTH-2:0], SI_R} :
             mode == MODE_SHR ? {SI_L, q[WIDTH-1:1]} :
             mode == MODE_ROL ? {q[WIDTH-2:0], q[WIDTH-1]} :
             mode == MODE_ROR ? {q[0], q[WIDTH-1:1]} :
             mode == MODE_ASR ? {q[WIDTH-1], q[WIDTH-1:1]} : q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: multi-step universal shift register with load, preset and done pulse
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int               WIDTH      = 8,
  parameter  logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  localparam int               AMT_W      = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             PR,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             SI_L,
  input  logic             SI_R,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             SO_L,
  output logic             SO_R
);
  state_t           state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [2:0]       op, op_n;
  logic [WIDTH-1:0] q_n, q_step;
  logic             busy_n, done_n;
  usr_step #(.WIDTH(WIDTH)) u_step (
    .q     (Q),
    .mode  (op),
    .SI_L  (SI_L),
    .SI_R  (SI_R),
    .q_next(q_step)
  );
  always_ff @(posedge clk)
    if (!CLR) begin
      state <= ST_IDLE;
      Q     <= '0;
      cnt   <= '0;
      op    <= MODE_SHL;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      Q     <= q_n;
      cnt   <= cnt_n;
      op    <= op_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  always_comb begin
    state_n = state;
    q_n     = Q;
    cnt_n   = cnt;
    op_n    = op;
    if (PR) begin
      state_n = ST_IDLE;
      q_n     = PRESET_VAL;
      cnt_n   = '0;
    end else if (state == ST_IDLE) begin
      if (load) q_n = D;
      else if (start) begin
        op_n    = mode;
        cnt_n   = amt;
        state_n = (amt == '0 || !mode_valid(mode)) ? ST_DONE : ST_SHIFT;
      end
    end else if (state == ST_SHIFT) begin
      q_n     = q_step;
      cnt_n   = cnt - AMT_W'(1);
      state_n = cnt == AMT_W'(1) ? ST_DONE : ST_SHIFT;
    end else state_n = ST_IDLE;
  end
  always_comb begin
    busy_n = state_n == ST_SHIFT;
    done_n = state_n == ST_DONE;
  end
  assign SO_L = Q[WIDTH-1];
  assign SO_R = Q[0];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg (WIDTH=8)
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH) + 1;
  logic             clk = 1'b0;
  logic             CLR, PR, load, start, SI_L, SI_R;
  logic [WIDTH-1:0] D;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] Q;
  logic             busy, done, SO_L, SO_R;
  int checks = 0;
  int errors = 0;
  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .CLR(CLR), .PR(PR), .D(D), .load(load), .start(start),
    .mode(mode), .amt(amt), .SI_L(SI_L), .SI_R(SI_R),
    .Q(Q), .busy(busy), .done(done), .SO_L(SO_L), .SO_R(SO_R)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [WIDTH-1:0] v);
    D = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic run_op(input logic [2:0] m, input logic [AMT_W-1:0] a, output int cyc);
    mode = m; amt = a; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask
  task automatic test_reset;
    CLR = 1'b0; PR = 1'b1; load = 1'b1; start = 1'b1; D = 8'hAA;
    mode = 3'b000; amt = 4'd3; SI_L = 1'b0; SI_R = 1'b0;
    tick();
    tick();
    checks++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: Q=%h busy=%b done=%b, required Q=00 busy=0 done=0", Q, busy, done);
    end
    CLR = 1'b1; PR = 1'b0; load = 1'b0; start = 1'b0;
    tick();
  endtask
  task automatic test_shl;
    int nb, nd, at;
    do_load(8'h56);
    checks++;
    if (Q !== 8'h56) begin
      errors++;
      $display("FAIL load: Q=%h, required 56", Q);
    end
    SI_R = 1'b0; mode = 3'b000; amt = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0; nd = 0; at = -1;
    for (int i = 0; i < 7; i++) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) begin nd++; at = i; end
      if (i == 3) begin
        checks++;
        if (Q !== 8'hB0) begin
          errors++;
          $display("FAIL shl_q: Q=%h, required B0", Q);
        end
      end
      tick();
    end
    checks++;
    if (nb != 3 || nd != 1 || at != 3) begin
      errors++;
      $display("FAIL shl_timing: busy_cycles=%0d done_pulses=%0d done_at=%0d, required 3 1 3", nb, nd, at);
    end
    checks++;
    if (SO_L !== 1'b1 || SO_R !== 1'b0) begin
      errors++;
      $display("FAIL serial_out: SO_L=%b SO_R=%b, required 1 0", SO_L, SO_R);
    end
  endtask
  task automatic test_rotate;
    int c;
    do_load(8'hF0);
    run_op(3'b011, 4'd4, c);
    tick();
    checks++;
    if (Q !== 8'h0F || c != 4) begin
      errors++;
      $display("FAIL ror: Q=%h cycles=%0d, required 0F 4", Q, c);
    end
    do_load(8'h80);
    run_op(3'b100, 4'd2, c);
    tick();
    checks++;
    if (Q !== 8'hE0 || c != 2) begin
      errors++;
      $display("FAIL asr: Q=%h cycles=%0d, required E0 2", Q, c);
    end
    do_load(8'h0F);
    SI_L = 1'b1;
    run_op(3'b001, 4'd2, c);
    SI_L = 1'b0;
    tick();
    checks++;
    if (Q !== 8'hC3) begin
      errors++;
      $display("FAIL shr: Q=%h, required C3", Q);
    end
    do_load(8'h81);
    run_op(3'b010, 4'd9, c);
    tick();
    checks++;
    if (Q !== 8'h03 || c != 9) begin
      errors++;
      $display("FAIL rol_long: Q=%h cycles=%0d, required 03 9", Q, c);
    end
  endtask
  task automatic test_no_shift;
    logic [2:0] ms [2] = '{3'b000, 3'b110};
    logic [AMT_W-1:0] as [2] = '{4'd0, 4'd3};
    do_load(8'h5A);
    for (int i = 0; i < 2; i++) begin
      mode = ms[i]; amt = as[i]; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || Q !== 8'h5A) begin
        errors++;
        $display("FAIL noshift_%0d: done=%b busy=%b Q=%h, required 1 0 5A", i, done, busy, Q);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || Q !== 8'h5A) begin
        errors++;
        $display("FAIL noshift_after_%0d: done=%b busy=%b Q=%h, required 0 0 5A", i, done, busy, Q);
      end
    end
  endtask
  task automatic test_preset_abort;
    int nd;
    do_load(8'h56);
    SI_R = 1'b0; mode = 3'b000; amt = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (Q !== 8'h58 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort: Q=%h busy=%b, required 58 1", Q, busy);
    end
    PR = 1'b1;
    tick();
    PR = 1'b0;
    nd = 0;
    checks++;
    if (Q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL preset: Q=%h busy=%b done=%b, required FF 0 0", Q, busy, done);
    end
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) nd++;
      tick();
    end
    checks++;
    if (nd != 0 || Q !== 8'hFF) begin
      errors++;
      $display("FAIL preset_idle: activity=%0d Q=%h, required 0 FF", nd, Q);
    end
  endtask
  task automatic test_load_start;
    int act;
    D = 8'h3C; load = 1'b1; start = 1'b1; mode = 3'b000; amt = 4'd3;
    tick();
    load = 1'b0; start = 1'b0;
    act = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1 || busy === 1'b1) act++;
      tick();
    end
    checks++;
    if (Q !== 8'h3C || act != 0) begin
      errors++;
      $display("FAIL load_start: Q=%h activity=%0d, required 3C 0", Q, act);
    end
  endtask
  task automatic test_ignore_busy;
    int c;
    do_load(8'h01);
    SI_R = 1'b0; mode = 3'b000; amt = 4'd3; start = 1'b1;
    tick();
    D = 8'hFF; load = 1'b1; mode = 3'b010; amt = 4'd1;
    c = 0;
    while (done !== 1'b1 && c < 40) begin
      tick();
      c++;
    end
    load = 1'b0; start = 1'b0;
    checks++;
    if (Q !== 8'h08 || c != 3) begin
      errors++;
      $display("FAIL ignore_busy: Q=%h cycles=%0d, required 08 3", Q, c);
    end
    tick();
  endtask
  task automatic test_back_to_back;
    int c;
    do_load(8'h81);
    run_op(3'b010, 4'd1, c);
    mode = 3'b010; amt = 4'd1; start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Q !== 8'h03) begin
      errors++;
      $display("FAIL b2b_ignored: busy=%b done=%b Q=%h, required 0 0 03", busy, done, Q);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || Q !== 8'h06) begin
      errors++;
      $display("FAIL b2b_result: done=%b Q=%h, required 1 06", done, Q);
    end
    tick();
  endtask
  task automatic test_clr_abort;
    int act;
    do_load(8'h56);
    SI_R = 1'b1; mode = 3'b000; amt = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    CLR = 1'b0;
    tick();
    CLR = 1'b1;
    SI_R = 1'b0;
    checks++;
    if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clr_abort: Q=%h busy=%b done=%b, required 00 0 0", Q, busy, done);
    end
    act = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) act++;
      tick();
    end
    checks++;
    if (act != 0 || Q !== 8'h00) begin
      errors++;
      $display("FAIL clr_idle: activity=%0d Q=%h, required 0 00", act, Q);
    end
  endtask
  initial begin
    test_reset();
    test_shl();
    test_rotate();
    test_no_shift();
    test_preset_abort();
    test_load_start();
    test_ignore_busy();
    test_back_to_back();
    test_clr_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
